// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_fsm
//  Purpose  : Multi-cycle processor control unit. Moore FSM sequencing
//             FETCH -> DECODE -> EXEC -> (MEM) -> (WB) with a sticky ERR
//             state for unsupported instructions.
//  Ports    : clk, reset (async, active-low)
//             op, func        - instruction fields (latched in DECODE)
//             zero, memReady  - datapath / memory status
//             pcWrite, irWrite, iord, memRead, writeMem, writeReg,
//             regDes, memToReg, aluSrcA, aluSrcB, aluc, pcSource
//                             - datapath controls
//             illegal         - sticky unsupported-instruction flag
//             state           - current state encoding (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       iord,
    output logic       memRead,
    output logic       writeMem,
    output logic       writeReg,
    output logic       regDes,
    output logic       memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluc,
    output logic [1:0] pcSource,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    state_t     r_state;
    logic [5:0] r_op;
    logic [5:0] r_func;
    // Low from reset until the first clock edge; the first FETCH cycle
    // only starts once this flop has seen an edge.
    logic       r_active;

    logic       r_pcw_jump;
    logic       r_pcw_beq;
    logic       r_iord;
    logic       r_mem_read;
    logic       r_write_mem;
    logic       r_write_reg;
    logic       r_reg_des;
    logic       r_mem_to_reg;
    logic       r_alu_src_a;
    logic [1:0] r_alu_src_b;
    logic [2:0] r_aluc;
    logic [1:0] r_pc_source;
    logic       r_illegal;

    // Instruction fields as they will be held next cycle: in DECODE the
    // live inputs are being captured, otherwise the latched copy is used.
    logic [5:0] w_op_nx;
    logic [5:0] w_func_nx;
    logic       w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_is_j;
    logic       w_r_legal;
    logic [2:0] w_r_aluc;
    logic       w_legal;
    state_t     w_next;

    logic       w_pcw_jump, w_pcw_beq, w_iord, w_mem_read, w_write_mem;
    logic       w_write_reg, w_reg_des, w_mem_to_reg, w_alu_src_a, w_illegal;
    logic [1:0] w_alu_src_b, w_pc_source;
    logic [2:0] w_aluc;
    logic       w_fetch_hs;

    assign w_op_nx   = (r_state == S_DECODE) ? op   : r_op;
    assign w_func_nx = (r_state == S_DECODE) ? func : r_func;

    assign w_is_r    = (w_op_nx == c_OP_RTYPE);
    assign w_is_lw   = (w_op_nx == c_OP_LW);
    assign w_is_sw   = (w_op_nx == c_OP_SW);
    assign w_is_beq  = (w_op_nx == c_OP_BEQ);
    assign w_is_addi = (w_op_nx == c_OP_ADDI);
    assign w_is_j    = (w_op_nx == c_OP_J);

    always_comb begin
        w_r_legal = 1'b1;
        w_r_aluc  = 3'b000;
        case (w_func_nx)
            6'b100000: w_r_aluc = 3'b000;
            6'b100010: w_r_aluc = 3'b001;
            6'b100100: w_r_aluc = 3'b010;
            6'b100101: w_r_aluc = 3'b011;
            6'b101010: w_r_aluc = 3'b100;
            default:   w_r_legal = 1'b0;
        endcase
    end

    assign w_legal = w_is_lw | w_is_sw | w_is_beq | w_is_addi | w_is_j
                   | (w_is_r & w_r_legal);

    always_comb begin
        w_next = r_state;
        if (!r_active) begin
            w_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  w_next = memReady ? S_DECODE : S_FETCH;
                S_DECODE: w_next = w_legal ? S_EXEC : S_ERR;
                S_EXEC: begin
                    if (w_is_lw || w_is_sw)        w_next = S_MEM;
                    else if (w_is_r || w_is_addi)  w_next = S_WB;
                    else                           w_next = S_FETCH;
                end
                S_MEM: begin
                    if (memReady) w_next = w_is_lw ? S_WB : S_FETCH;
                end
                S_WB:     w_next = S_FETCH;
                S_ERR:    w_next = S_ERR;
                default:  w_next = S_FETCH;
            endcase
        end
    end

    // Moore outputs for the state being entered; registered below so they
    // are glitch-free and constant for the whole state.
    always_comb begin
        w_pcw_jump   = 1'b0;
        w_pcw_beq    = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_write_mem  = 1'b0;
        w_write_reg  = 1'b0;
        w_reg_des    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_aluc       = 3'b000;
        w_pc_source  = 2'b00;
        w_illegal    = 1'b0;
        case (w_next)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
            end
            S_DECODE: w_alu_src_b = 2'b10;
            S_EXEC: begin
                if (w_is_r) begin
                    w_alu_src_a = 1'b1;
                    w_aluc      = w_r_aluc;
                end else if (w_is_lw || w_is_sw || w_is_addi) begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'b10;
                end else if (w_is_beq) begin
                    w_alu_src_a = 1'b1;
                    w_aluc      = 3'b001;
                    w_pc_source = 2'b01;
                    w_pcw_beq   = 1'b1;
                end else if (w_is_j) begin
                    w_pc_source = 2'b10;
                    w_pcw_jump  = 1'b1;
                end
            end
            S_MEM: begin
                w_iord      = 1'b1;
                w_mem_read  = w_is_lw;
                w_write_mem = w_is_sw;
            end
            S_WB: begin
                w_write_reg  = 1'b1;
                w_reg_des    = ~w_is_r;
                w_mem_to_reg = w_is_lw;
            end
            S_ERR:   w_illegal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_op         <= 6'd0;
            r_func       <= 6'd0;
            r_active     <= 1'b0;
            r_pcw_jump   <= 1'b0;
            r_pcw_beq    <= 1'b0;
            r_iord       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_write_mem  <= 1'b0;
            r_write_reg  <= 1'b0;
            r_reg_des    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 2'b00;
            r_aluc       <= 3'b000;
            r_pc_source  <= 2'b00;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_op         <= w_op_nx;
            r_func       <= w_func_nx;
            r_active     <= 1'b1;
            r_pcw_jump   <= w_pcw_jump;
            r_pcw_beq    <= w_pcw_beq;
            r_iord       <= w_iord;
            r_mem_read   <= w_mem_read;
            r_write_mem  <= w_write_mem;
            r_write_reg  <= w_write_reg;
            r_reg_des    <= w_reg_des;
            r_mem_to_reg <= w_mem_to_reg;
            r_alu_src_a  <= w_alu_src_a;
            r_alu_src_b  <= w_alu_src_b;
            r_aluc       <= w_aluc;
            r_pc_source  <= w_pc_source;
            r_illegal    <= w_illegal;
        end
    end

    // Fetch handshake is the only memReady-dependent strobe; gating with
    // r_active keeps it low while reset is held and before the first edge.
    assign w_fetch_hs = r_active & (r_state == S_FETCH) & memReady;

    assign pcWrite  = w_fetch_hs | r_pcw_jump | (r_pcw_beq & zero);
    assign irWrite  = w_fetch_hs;
    assign iord     = r_iord;
    assign memRead  = r_mem_read;
    assign writeMem = r_write_mem;
    assign writeReg = r_write_reg;
    assign regDes   = r_reg_des;
    assign memToReg = r_mem_to_reg;
    assign aluSrcA  = r_alu_src_a;
    assign aluSrcB  = r_alu_src_b;
    assign aluc     = r_aluc;
    assign pcSource = r_pc_source;
    assign illegal  = r_illegal;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_fsm
//  Purpose  : Directed self-checking bench for ctrl_fsm. Each step drives the
//             inputs for one cycle, queues the expected output vector and
//             compares it against the DUT mid-cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

    localparam logic [5:0] c_R    = 6'b000000;
    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_FADD = 6'b100000;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, iord, mr, wm, wr, rd, m2r, asa;
        logic [1:0] asb;
        logic [2:0] alu;
        logic [1:0] pcs;
        logic       ill;
    } outv_t;

    logic       clk;
    logic       reset;
    logic [5:0] op, func;
    logic       zero, memReady;
    logic       pcWrite, irWrite, iord, memRead, writeMem, writeReg;
    logic       regDes, memToReg, aluSrcA, illegal;
    logic [1:0] aluSrcB, pcSource;
    logic [2:0] aluc, state;

    int    nvec  = 0;
    int    nfail = 0;
    outv_t sb[$];

    ctrl_fsm dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite),
        .iord(iord), .memRead(memRead), .writeMem(writeMem),
        .writeReg(writeReg), .regDes(regDes), .memToReg(memToReg),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluc(aluc),
        .pcSource(pcSource), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vectors per state, straight from the state/output table.
    function automatic outv_t e_rst();
        outv_t v = '0;
        return v;
    endfunction
    function automatic outv_t e_fetch(input logic m);
        outv_t v = '0;
        v.st = 3'd0; v.mr = 1'b1; v.asb = 2'b01; v.pcw = m; v.irw = m;
        return v;
    endfunction
    function automatic outv_t e_decode();
        outv_t v = '0;
        v.st = 3'd1; v.asb = 2'b10;
        return v;
    endfunction
    function automatic outv_t e_exec_r(input logic [2:0] a);
        outv_t v = '0;
        v.st = 3'd2; v.asa = 1'b1; v.alu = a;
        return v;
    endfunction
    function automatic outv_t e_exec_i();
        outv_t v = '0;
        v.st = 3'd2; v.asa = 1'b1; v.asb = 2'b10;
        return v;
    endfunction
    function automatic outv_t e_exec_beq(input logic z);
        outv_t v = '0;
        v.st = 3'd2; v.asa = 1'b1; v.alu = 3'b001; v.pcs = 2'b01; v.pcw = z;
        return v;
    endfunction
    function automatic outv_t e_exec_j();
        outv_t v = '0;
        v.st = 3'd2; v.pcs = 2'b10; v.pcw = 1'b1;
        return v;
    endfunction
    function automatic outv_t e_mem(input logic is_lw);
        outv_t v = '0;
        v.st = 3'd3; v.iord = 1'b1; v.mr = is_lw; v.wm = ~is_lw;
        return v;
    endfunction
    function automatic outv_t e_wb(input logic rd, input logic m2r);
        outv_t v = '0;
        v.st = 3'd4; v.wr = 1'b1; v.rd = rd; v.m2r = m2r;
        return v;
    endfunction
    function automatic outv_t e_err();
        outv_t v = '0;
        v.st = 3'd7; v.ill = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input outv_t e);
        outv_t obs, exp_v;
        sb.push_back(e);
        #1;
        exp_v = sb.pop_front();
        obs = {state, pcWrite, irWrite, iord, memRead, writeMem, writeReg,
               regDes, memToReg, aluSrcA, aluSrcB, aluc, pcSource, illegal};
        nvec++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                        input logic m, input logic z, input outv_t e);
        @(negedge clk);
        op = o; func = f; memReady = m; zero = z;
        chk(tag, e);
    endtask

    // Asynchronous reset mid-cycle, hold for one cycle, release at a negedge.
    task automatic hit_reset(input string tag);
        reset = 1'b0;
        chk(tag, e_rst());
        step({tag, "_hold"}, 6'd0, 6'd0, 1'b1, 1'b0, e_rst());
        @(negedge clk);
        reset = 1'b1;
        chk({tag, "_rel"}, e_rst());
    endtask

    initial begin
        reset = 1'b0; op = '0; func = '0; zero = 1'b0; memReady = 1'b0;
        repeat (2) @(posedge clk);
        step("reset_held", c_R, c_FADD, 1'b1, 1'b0, e_rst());
        @(negedge clk);
        reset = 1'b1;
        chk("pre_first_edge", e_rst());

        // add; op/func scrambled after DECODE, memReady noise in EXEC/WB
        step("add_fetch_wait", c_R, c_FADD, 1'b0, 1'b0, e_fetch(1'b0));
        step("add_fetch", c_R, c_FADD, 1'b1, 1'b0, e_fetch(1'b1));
        step("add_decode", c_R, c_FADD, 1'b0, 1'b0, e_decode());
        step("add_exec", 6'h3f, 6'h00, 1'b1, 1'b0, e_exec_r(3'b000));
        step("add_wb", 6'h3f, 6'h00, 1'b1, 1'b0, e_wb(1'b0, 1'b0));

        // remaining R-type functions
        begin
            logic [5:0] fn [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
            logic [2:0] al [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
            for (int i = 0; i < 4; i++) begin
                step("r_fetch", c_R, fn[i], 1'b1, 1'b0, e_fetch(1'b1));
                step("r_decode", c_R, fn[i], 1'b1, 1'b0, e_decode());
                step("r_exec", c_R, fn[i], 1'b1, 1'b0, e_exec_r(al[i]));
                step("r_wb", c_R, fn[i], 1'b1, 1'b0, e_wb(1'b0, 1'b0));
            end
        end

        // addi
        step("addi_fetch", c_ADDI, 6'd0, 1'b1, 1'b0, e_fetch(1'b1));
        step("addi_decode", c_ADDI, 6'd0, 1'b1, 1'b0, e_decode());
        step("addi_exec", c_ADDI, 6'd0, 1'b1, 1'b0, e_exec_i());
        step("addi_wb", c_ADDI, 6'd0, 1'b1, 1'b0, e_wb(1'b1, 1'b0));

        // lw with three wait cycles in MEM
        step("lw_fetch", c_LW, 6'd0, 1'b1, 1'b0, e_fetch(1'b1));
        step("lw_decode", c_LW, 6'd0, 1'b0, 1'b0, e_decode());
        step("lw_exec", c_LW, 6'd0, 1'b0, 1'b0, e_exec_i());
        for (int i = 0; i < 3; i++)
            step("lw_mem_wait", c_LW, 6'd0, 1'b0, 1'b0, e_mem(1'b1));
        step("lw_mem_done", c_LW, 6'd0, 1'b1, 1'b0, e_mem(1'b1));
        step("lw_wb", c_LW, 6'd0, 1'b1, 1'b0, e_wb(1'b1, 1'b1));

        // lw, no waits: five cycles
        step("lw2_fetch", c_LW, 6'd0, 1'b1, 1'b0, e_fetch(1'b1));
        step("lw2_decode", c_LW, 6'd0, 1'b1, 1'b0, e_decode());
        step("lw2_exec", c_LW, 6'd0, 1'b1, 1'b0, e_exec_i());
        step("lw2_mem", c_LW, 6'd0, 1'b1, 1'b0, e_mem(1'b1));
        step("lw2_wb", c_LW, 6'd0, 1'b1, 1'b0, e_wb(1'b1, 1'b1));

        // sw: four cycles
        step("sw_fetch", c_SW, 6'd0, 1'b1, 1'b0, e_fetch(1'b1));
        step("sw_decode", c_SW, 6'd0, 1'b1, 1'b0, e_decode());
        step("sw_exec", c_SW, 6'd0, 1'b1, 1'b0, e_exec_i());
        step("sw_mem", c_SW, 6'd0, 1'b1, 1'b0, e_mem(1'b0));

        // beq taken then not taken: three cycles each
        step("beq1_fetch", c_BEQ, 6'd0, 1'b1, 1'b1, e_fetch(1'b1));
        step("beq1_decode", c_BEQ, 6'd0, 1'b1, 1'b1, e_decode());
        step("beq1_exec", c_BEQ, 6'd0, 1'b1, 1'b1, e_exec_beq(1'b1));
        step("beq0_fetch", c_BEQ, 6'd0, 1'b1, 1'b0, e_fetch(1'b1));
        step("beq0_decode", c_BEQ, 6'd0, 1'b1, 1'b1, e_decode());
        step("beq0_exec", c_BEQ, 6'd0, 1'b1, 1'b0, e_exec_beq(1'b0));

        // j: three cycles
        step("j_fetch", c_J, 6'd0, 1'b1, 1'b0, e_fetch(1'b1));
        step("j_decode", c_J, 6'd0, 1'b1, 1'b0, e_decode());
        step("j_exec", c_J, 6'd0, 1'b1, 1'b0, e_exec_j());

        // sw aborted by reset while waiting in MEM
        step("swr_fetch", c_SW, 6'd0, 1'b1, 1'b0, e_fetch(1'b1));
        step("swr_decode", c_SW, 6'd0, 1'b1, 1'b0, e_decode());
        step("swr_exec", c_SW, 6'd0, 1'b0, 1'b0, e_exec_i());
        step("swr_mem_wait", c_SW, 6'd0, 1'b0, 1'b0, e_mem(1'b0));
        hit_reset("swr_abort");
        step("swr_after", c_SW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));

        // R-type with unsupported func
        step("badf_fetch", c_R, 6'b000111, 1'b1, 1'b0, e_fetch(1'b1));
        step("badf_decode", c_R, 6'b000111, 1'b1, 1'b0, e_decode());
        step("badf_err", c_R, 6'b000111, 1'b1, 1'b0, e_err());
        step("badf_err2", c_FADD, c_FADD, 1'b1, 1'b0, e_err());
        hit_reset("badf_rst");

        // unsupported opcode
        step("badop_fetch", 6'h3f, 6'd0, 1'b1, 1'b0, e_fetch(1'b1));
        step("badop_decode", 6'h3f, 6'd0, 1'b1, 1'b0, e_decode());
        for (int i = 0; i < 3; i++)
            step("badop_err", c_J, 6'd0, 1'b1, 1'b0, e_err());
        hit_reset("badop_rst");
        step("post_fetch", c_R, c_FADD, 1'b1, 1'b0, e_fetch(1'b1));
        step("post_decode", c_R, c_FADD, 1'b1, 1'b0, e_decode());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
